conv_ctrl_param: RTL

Parametrised successor of the convolution accelerator's sequencing controller. It owns its own loop counters and memory address generation instead of consuming external carry-outs. It adds a memory-ready stall handshake, a busy/done handshake and a configurable output grouping with partial final-group flush. It sits between the shared memory port and the datapath (filter file, image slice buffer, MAC accumulator, result register).

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_ctrl_param_counter.sv | 31 +++
 rtl/conv_ctrl_param.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencing controller: state encoding,
// default address constants and a counter-width helper.
package conv_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_FILTER,
        S_NEXT_FILTER,
        S_LD_SLICE,
        S_LD_BUFFER,
        S_MAC,
        S_LD_RESULT,
        S_WRITE_MEM,
        S_UPDATE,
        S_INC_OFFSET,
        S_DONE
    } state_t;

    localparam int DEF_AW       = 16;
    localparam int DEF_IMG_BASE = 'h0100;
    localparam int DEF_OUT_BASE = 'h0800;

    // Bit width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_ctrl_param_counter.sv
// Modulo-MAX loop counter with enable, synchronous clear and terminal-count flag.
module ctrl_counter
    import conv_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    output logic [cw(MAX)-1:0]  value,
    output logic                last
);

    localparam int             W   = cw(MAX);
    localparam logic [W-1:0]   TOP = W'(MAX - 1);

    logic [W-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_reg <= '0;
        end else if (en) begin
            value_reg <= (value_reg == TOP) ? '0 : value_reg + 1'b1;
        end
    end

    assign value = value_reg;
    assign last  = (value_reg == TOP);

endmodule

// File: rtl/conv_ctrl_param.sv
// Sequencing controller for the convolution accelerator: owns its loop counters,
// memory address generation, the memory stall handshake and grouped output writes.
module conv_ctrl_param
    import conv_pkg::*;
#(
    parameter int            AW           = DEF_AW,
    parameter int            FILTER_LEN   = 4,
    parameter int            NUM_FILTERS  = 4,
    parameter int            SLICE_LEN    = 16,
    parameter int            BUF_ROWS     = 4,
    parameter int            MAC_LEN      = 16,
    parameter int            COLS         = 13,
    parameter int            GROUP        = 4,
    parameter int            NUM_OUT      = 43,
    parameter logic [AW-1:0] IMG_BASE     = AW'(DEF_IMG_BASE),
    parameter logic [AW-1:0] OUT_BASE     = AW'(DEF_OUT_BASE),
    parameter int            SLICE_STRIDE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mem_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [AW-1:0]                mem_addr,
    output logic                         filter_wr_en,
    output logic [cw(NUM_FILTERS)-1:0]   filter_idx,
    output logic                         img_wr_en,
    output logic                         img_slice_en,
    output logic                         acc_en,
    output logic                         rst_acc,
    output logic                         res_buffer_en,
    output logic                         rst_res_reg,
    output logic [cw(NUM_OUT+1)-1:0]     out_count
);

    localparam int KW  = cw(FILTER_LEN);
    localparam int FW  = cw(NUM_FILTERS);
    localparam int IW  = cw(SLICE_LEN);
    localparam int RW  = cw(BUF_ROWS);
    localparam int MW  = cw(MAC_LEN);
    localparam int CLW = cw(COLS);
    localparam int GW  = cw(GROUP);
    localparam int OW  = cw(NUM_OUT + 1);

    localparam logic [OW-1:0] LAST_OUT    = OW'(NUM_OUT - 1);
    localparam logic [OW-1:0] ALL_OUT     = OW'(NUM_OUT);
    localparam logic [AW-1:0] FILTER_STEP = AW'(FILTER_LEN);
    localparam logic [AW-1:0] STRIDE_STEP = AW'(SLICE_STRIDE);

    state_t          state_reg;
    logic [AW-1:0]   offset_reg;
    logic [OW-1:0]   prod_reg;
    logic [OW-1:0]   out_count_reg;
    logic            rst_res_pulse_reg;

    logic [KW-1:0]   k_val;
    logic [FW-1:0]   fi_val;
    logic [IW-1:0]   i_val;
    logic [RW-1:0]   row_val;
    logic [MW-1:0]   mac_val;
    logic [CLW-1:0]  col_val;
    logic [GW-1:0]   grp_val;
    logic            k_last, fi_last, i_last, row_last, mac_last, col_last, grp_last;

    logic            run_clr;
    logic            wr_accept;
    logic            unused_cnt;

    assign run_clr   = (state_reg == S_IDLE) && start;
    assign wr_accept = (state_reg == S_WRITE_MEM) && mem_ready;

    // Loop counters; every one is cleared when a run begins.
    ctrl_counter #(.MAX(FILTER_LEN)) u_k (
        .clk(clk), .rst(rst), .en((state_reg == S_LD_FILTER) && mem_ready),
        .clr(run_clr), .value(k_val), .last(k_last)
    );

    ctrl_counter #(.MAX(NUM_FILTERS)) u_filter (
        .clk(clk), .rst(rst), .en(state_reg == S_NEXT_FILTER),
        .clr(run_clr), .value(fi_val), .last(fi_last)
    );

    ctrl_counter #(.MAX(SLICE_LEN)) u_i (
        .clk(clk), .rst(rst), .en((state_reg == S_LD_SLICE) && mem_ready),
        .clr(run_clr), .value(i_val), .last(i_last)
    );

    ctrl_counter #(.MAX(BUF_ROWS)) u_row (
        .clk(clk), .rst(rst), .en(state_reg == S_LD_BUFFER),
        .clr(run_clr), .value(row_val), .last(row_last)
    );

    ctrl_counter #(.MAX(MAC_LEN)) u_mac (
        .clk(clk), .rst(rst), .en(state_reg == S_MAC),
        .clr(run_clr), .value(mac_val), .last(mac_last)
    );

    ctrl_counter #(.MAX(COLS)) u_col (
        .clk(clk), .rst(rst), .en(state_reg == S_UPDATE),
        .clr(run_clr), .value(col_val), .last(col_last)
    );

    // A flushed partial group restarts the group count on the write accept.
    ctrl_counter #(.MAX(GROUP)) u_grp (
        .clk(clk), .rst(rst), .en(state_reg == S_LD_RESULT),
        .clr(run_clr || wr_accept), .value(grp_val), .last(grp_last)
    );

    assign unused_cnt = ^{row_val, mac_val, col_val, grp_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            offset_reg        <= '0;
            prod_reg          <= '0;
            out_count_reg     <= '0;
            rst_res_pulse_reg <= 1'b0;
        end else begin
            rst_res_pulse_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg     <= S_LD_FILTER;
                        offset_reg    <= '0;
                        prod_reg      <= '0;
                        out_count_reg <= '0;
                    end
                end
                S_LD_FILTER: begin
                    if (mem_ready && k_last) begin
                        state_reg <= S_NEXT_FILTER;
                    end
                end
                S_NEXT_FILTER: begin
                    state_reg <= fi_last ? S_LD_SLICE : S_LD_FILTER;
                end
                S_LD_SLICE: begin
                    if (mem_ready && i_last) begin
                        state_reg <= S_LD_BUFFER;
                    end
                end
                S_LD_BUFFER: begin
                    if (row_last) begin
                        state_reg <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (mac_last) begin
                        state_reg <= S_LD_RESULT;
                    end
                end
                S_LD_RESULT: begin
                    prod_reg  <= prod_reg + 1'b1;
                    state_reg <= (grp_last || (prod_reg == LAST_OUT)) ? S_WRITE_MEM : S_UPDATE;
                end
                S_WRITE_MEM: begin
                    if (mem_ready) begin
                        out_count_reg     <= out_count_reg + 1'b1;
                        rst_res_pulse_reg <= 1'b1;
                        state_reg         <= (prod_reg == ALL_OUT) ? S_DONE : S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    state_reg <= col_last ? S_INC_OFFSET : S_LD_BUFFER;
                end
                S_INC_OFFSET: begin
                    offset_reg <= offset_reg + STRIDE_STEP;
                    state_reg  <= S_LD_SLICE;
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode: strobes and address depend only on state and counters.
    always_comb begin
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        filter_wr_en  = 1'b0;
        img_wr_en     = 1'b0;
        img_slice_en  = 1'b0;
        acc_en        = 1'b0;
        rst_acc       = 1'b0;
        res_buffer_en = 1'b0;
        done          = 1'b0;
        case (state_reg)
            S_LD_FILTER: begin
                mem_rd       = 1'b1;
                filter_wr_en = 1'b1;
                mem_addr     = AW'(fi_val) * FILTER_STEP + AW'(k_val);
            end
            S_LD_SLICE: begin
                mem_rd    = 1'b1;
                img_wr_en = 1'b1;
                mem_addr  = IMG_BASE + offset_reg + AW'(i_val);
            end
            S_LD_BUFFER: img_slice_en = 1'b1;
            S_MAC:       acc_en       = 1'b1;
            S_LD_RESULT: begin
                res_buffer_en = 1'b1;
                rst_acc       = 1'b1;
            end
            S_WRITE_MEM: begin
                mem_wr   = 1'b1;
                mem_addr = OUT_BASE + AW'(out_count_reg);
            end
            S_DONE:      done = 1'b1;
            default: begin
            end
        endcase
    end

    assign busy        = (state_reg != S_IDLE);
    assign filter_idx  = fi_val;
    assign out_count   = out_count_reg;
    assign rst_res_reg = rst_res_pulse_reg;

endmodule
